// File: rtl/ddr_port_arbiter_if.sv
// rtl/ddr_port_arbiter_if.sv - picorv-style memory port (la_addr/wdata/wstrb/valid -> rdata/ready).
interface ddr_port_arbiter_if #(
  parameter int AW = 25,
  parameter int DW = 32
);
  logic [AW-1:0]   la_addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            valid;
  logic [DW-1:0]   rdata;
  logic            ready;

  // master issues requests; slave answers them
  modport master (
    output la_addr, wdata, wstrb, valid,
    input  rdata, ready
  );

  modport slave (
    input  la_addr, wdata, wstrb, valid,
    output rdata, ready
  );
endinterface

// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - two-master round-robin arbiter in front of the DDR bridge port.
// One transaction in flight; downstream request and upstream response are fully registered.
module ddr_port_arbiter #(
  parameter int AW = 25,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ddr_port_arbiter_if.slave    m0,
  ddr_port_arbiter_if.slave    m1,
  ddr_port_arbiter_if.master   ddr,
  output logic                 grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            grant_q, grant_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;
  logic            ready0_q, ready0_d;
  logic            ready1_q, ready1_d;
  logic            sel;

  // Contention is settled by the pointer; a lone requester always wins.
  assign sel = (m0.valid && m1.valid) ? ptr_q : m1.valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      grant_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      valid_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ready0_q <= 1'b0;
      ready1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      valid_q  <= valid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ready0_q <= ready0_d;
      ready1_q <= ready1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    valid_d  = valid_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ready0_d = 1'b0;
    ready1_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0.valid || m1.valid) begin
          addr_d  = sel ? m1.la_addr : m0.la_addr;
          wdata_d = sel ? m1.wdata   : m0.wdata;
          wstrb_d = sel ? m1.wstrb   : m0.wstrb;
          valid_d = 1'b1;
          grant_d = sel;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Request registers stay frozen until the bridge completes.
        if (ddr.ready) begin
          if (grant_q) begin
            rdata1_d = ddr.rdata;
            ready1_d = 1'b1;
          end else begin
            rdata0_d = ddr.rdata;
            ready0_d = 1'b1;
          end
          valid_d = 1'b0;
          ptr_d   = ~grant_q;
          state_d = RESP;
        end
      end
      RESP: begin
        // Lets the served master drop valid before arbitration resumes.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign ddr.la_addr = addr_q;
  assign ddr.wdata   = wdata_q;
  assign ddr.wstrb   = wstrb_q;
  assign ddr.valid   = valid_q;
  assign m0.rdata    = rdata0_q;
  assign m0.ready    = ready0_q;
  assign m1.rdata    = rdata1_q;
  assign m1.ready    = ready1_q;
  assign grant       = grant_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb/tb_ddr_port_arbiter.sv - self-checking bench for ddr_port_arbiter.
module tb_ddr_port_arbiter;
  localparam int AW = 25;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] rdata;
  } req_t;

  typedef struct {
    bit   req0;
    bit   req1;
    req_t r0;
    req_t r1;
    int   lat;
    bit   first;
    bit   scramble;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic grant;

  ddr_port_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  ddr_port_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
  ddr_port_arbiter_if #(.AW(AW), .DW(DW)) ddr_if ();

  ddr_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_if),
    .m1    (m1_if),
    .ddr   (ddr_if),
    .grant (grant)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            exp_q[$];
  req_t          rec[2];
  int            remaining[2];
  bit            reissue[2];
  logic [DW-1:0] last_rdata[2];
  vec_t          vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic req_t mk_req(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                  input logic [SW-1:0] s, input logic [DW-1:0] r);
    req_t q;
    q.addr = a; q.wdata = d; q.wstrb = s; q.rdata = r;
    return q;
  endfunction

  function automatic req_t rand_req();
    return mk_req(AW'($urandom), $urandom, SW'($urandom), $urandom);
  endfunction

  function automatic vec_t mk_vec(input bit q0, input bit q1, input req_t r0, input req_t r1,
                                  input int lat, input bit first, input bit scr);
    vec_t v;
    v.req0 = q0; v.req1 = q1; v.r0 = r0; v.r1 = r1;
    v.lat = lat; v.first = first; v.scramble = scr;
    return v;
  endfunction

  function automatic logic get_ready(input int i);
    return (i == 0) ? m0_if.ready : m1_if.ready;
  endfunction

  function automatic logic [DW-1:0] get_rdata(input int i);
    return (i == 0) ? m0_if.rdata : m1_if.rdata;
  endfunction

  task automatic drive_req(input int i);
    if (i == 0) begin
      m0_if.la_addr = rec[0].addr; m0_if.wdata = rec[0].wdata; m0_if.wstrb = rec[0].wstrb;
    end else begin
      m1_if.la_addr = rec[1].addr; m1_if.wdata = rec[1].wdata; m1_if.wstrb = rec[1].wstrb;
    end
  endtask

  task automatic set_valid(input int i, input logic v);
    if (i == 0) m0_if.valid = v;
    else        m1_if.valid = v;
  endtask

  // Bridge model + master models, all acting at negedge. Grant order comes from exp_q.
  task automatic run_engine(input int lat, input bit scramble);
    int cyc = 0;
    bit in_txn = 0;
    bit resp_due = 0;
    bit first = 1;
    int cnt = 0;
    int g = 0;
    while ((remaining[0] + remaining[1] > 0) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      ddr_if.ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (reissue[i]) begin
          reissue[i] = 0;
          rec[i] = rand_req();
          drive_req(i);
          set_valid(i, 1'b1);
        end
      end
      if (resp_due) begin
        resp_due = 0;
        chk("ready_owner", get_ready(g), 1'b1);
        chk("ready_other", get_ready(1 - g), 1'b0);
        chk("rdata_owner", get_rdata(g), rec[g].rdata);
        chk("rdata_other_hold", get_rdata(1 - g), last_rdata[1 - g]);
        last_rdata[g] = rec[g].rdata;
        set_valid(g, 1'b0);
        remaining[g]--;
        if (remaining[g] > 0) reissue[g] = 1;
        ddr_if.rdata = $urandom;
      end else begin
        chk("no_ready_pulse", {m1_if.ready, m0_if.ready}, 2'b00);
      end
      if (ddr_if.valid) begin
        if (!in_txn) begin
          in_txn = 1;
          cnt = lat;
          chk("exp_q_nonempty", exp_q.size() != 0, 1'b1);
          g = (exp_q.size() != 0) ? exp_q.pop_front() : int'(grant);
          if (first) chk("req_latency", cyc, 1);
          first = 0;
        end
        chk("grant", grant, g[0]);
        chk("ddr_la_addr", ddr_if.la_addr, rec[g].addr);
        chk("ddr_wdata", ddr_if.wdata, rec[g].wdata);
        chk("ddr_wstrb", ddr_if.wstrb, rec[g].wstrb);
        if (scramble) begin
          if (g == 0) begin m0_if.la_addr = AW'($urandom); m0_if.wdata = $urandom; end
          else        begin m1_if.la_addr = AW'($urandom); m1_if.wdata = $urandom; end
        end
        if (cnt == 0) begin
          ddr_if.ready = 1'b1;
          ddr_if.rdata = rec[g].rdata;
          in_txn = 0;
          resp_due = 1;
        end else begin
          cnt--;
        end
      end else if (in_txn) begin
        chk("ddr_valid_held", ddr_if.valid, 1'b1);
      end
    end
    chk("engine_done", remaining[0] + remaining[1], 0);
    remaining[0] = 0; remaining[1] = 0;
    exp_q.delete();
  endtask

  task automatic apply_row(input vec_t v);
    @(negedge clk);
    rec[0] = v.r0; rec[1] = v.r1;
    drive_req(0); drive_req(1);
    remaining[0] = int'(v.req0); remaining[1] = int'(v.req1);
    set_valid(0, v.req0); set_valid(1, v.req1);
    exp_q.push_back(int'(v.first));
    if (v.req0 && v.req1) exp_q.push_back(int'(!v.first));
    run_engine(v.lat, v.scramble);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk_vec(1, 0, mk_req(25'h0000100, 32'h0, 4'h0, 32'hDEADBEEF),
                     mk_req('0, '0, '0, '0), 2, 0, 0);
    vecs[1] = mk_vec(0, 1, mk_req('0, '0, '0, '0),
                     mk_req(25'h1FFFFFF, 32'h12345678, 4'hF, 32'h0BADF00D), 10, 1, 0);
    vecs[2] = mk_vec(1, 1, mk_req(25'h00ABCDE, 32'h0, 4'h0, 32'h11111111),
                     mk_req(25'h1000000, 32'hCAFEF00D, 4'h3, 32'h22222222), 1, 0, 0);
    vecs[3] = mk_vec(1, 0, mk_req(25'h0000004, 32'hFFFFFFFF, 4'h1, 32'h33333333),
                     mk_req('0, '0, '0, '0), 4, 0, 1);
    vecs[4] = mk_vec(1, 1, mk_req(25'h0155555, 32'h55AA55AA, 4'hC, 32'h44444444),
                     mk_req(25'h0AAAAAA, 32'h0, 4'h0, 32'h55555555), 0, 1, 0);
    vecs[5] = mk_vec(1, 0, mk_req(25'h0000000, 32'h0, 4'h0, 32'hFFFFFFFF),
                     mk_req('0, '0, '0, '0), 3, 0, 0);
    vecs[6] = mk_vec(1, 1, mk_req(25'h1234567, 32'h89ABCDEF, 4'h8, 32'h66666666),
                     mk_req(25'h0765432, 32'h01234567, 4'h6, 32'h77777777), 2, 1, 1);
    vecs[7] = mk_vec(1, 0, mk_req(25'h0000100, 32'h0, 4'h0, 32'h8BADCAFE),
                     mk_req('0, '0, '0, '0), 1, 0, 0);
    vecs[8] = mk_vec(1, 1, mk_req(25'h0000200, 32'h0, 4'h0, 32'h13579BDF),
                     mk_req(25'h0000300, 32'hA5A5A5A5, 4'hF, 32'h2468ACE0), 1, 0, 0);

    m0_if.la_addr = '0; m0_if.wdata = '0; m0_if.wstrb = '0; m0_if.valid = 1'b0;
    m1_if.la_addr = '0; m1_if.wdata = '0; m1_if.wstrb = '0; m1_if.valid = 1'b0;
    ddr_if.rdata = '0; ddr_if.ready = 1'b0;
    last_rdata[0] = '0; last_rdata[1] = '0;
    remaining[0] = 0; remaining[1] = 0;
    reissue[0] = 0; reissue[1] = 0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ddr_valid", ddr_if.valid, 1'b0);
    chk("reset_ddr_la_addr", ddr_if.la_addr, '0);
    chk("reset_grant", grant, 1'b0);
    chk("reset_ready", {m1_if.ready, m0_if.ready}, 2'b00);
    chk("reset_rdata", {m1_if.rdata, m0_if.rdata}, 64'h0);

    // Pointer trace: A->1 B->0 C->0 D->1 E->1 F->1 G->1
    for (int i = 0; i < 7; i++) apply_row(vecs[i]);

    // Both masters request continuously; pointer is 1 here.
    @(negedge clk);
    rec[0] = rand_req(); rec[1] = rand_req();
    drive_req(0); drive_req(1);
    remaining[0] = 4; remaining[1] = 4;
    set_valid(0, 1'b1); set_valid(1, 1'b1);
    for (int k = 0; k < 8; k++) exp_q.push_back((k + 1) % 2);
    run_engine(0, 0);

    // Spurious ddr_ready while idle.
    @(negedge clk);
    ddr_if.ready = 1'b1;
    ddr_if.rdata = 32'hBAD0BAD0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("spurious_ready", {m1_if.ready, m0_if.ready}, 2'b00);
      chk("spurious_ddr_valid", ddr_if.valid, 1'b0);
    end
    ddr_if.ready = 1'b0;
    chk("spurious_rdata0_hold", m0_if.rdata, last_rdata[0]);
    chk("spurious_rdata1_hold", m1_if.rdata, last_rdata[1]);
    apply_row(vecs[7]);

    // Reset while master 1 is in BUSY, pointer currently 1.
    @(negedge clk);
    rec[1] = rand_req();
    drive_req(1);
    set_valid(1, 1'b1);
    @(negedge clk);
    chk("prereset_ddr_valid", ddr_if.valid, 1'b1);
    chk("prereset_grant", grant, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ddr_valid", ddr_if.valid, 1'b0);
    chk("async_grant", grant, 1'b0);
    chk("async_ready", {m1_if.ready, m0_if.ready}, 2'b00);
    chk("async_rdata", {m1_if.rdata, m0_if.rdata}, 64'h0);
    set_valid(1, 1'b0);
    last_rdata[0] = '0; last_rdata[1] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply_row(vecs[8]);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
